// File: rtl/mips_sys_pkg.sv
// mips_sys_pkg: syscall code constants and syscall FSM state type
package mips_sys_pkg;
    localparam logic [31:0] SYS_PRINT = 32'd34;
    localparam logic [31:0] SYS_EXIT  = 32'd10;
    localparam logic [31:0] SYS_PAUSE = 32'd50;
    typedef enum logic [1:0] {IDLE, PAUSE, RESUME, HALT} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (inc && q != '1) q <= q + W'(1);
endmodule

// File: rtl/syscall_unit.sv
// syscall_unit: decodes SYSCALL for print/pause/exit and stalls the CPU accordingly
module syscall_unit
    import mips_sys_pkg::*;
#(
    parameter logic [31:0] V0_PRINT = SYS_PRINT,
    parameter logic [31:0] V0_EXIT  = SYS_EXIT,
    parameter logic [31:0] V0_PAUSE = SYS_PAUSE,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             syscall,
    input  logic [31:0]      v0,
    input  logic [31:0]      a0,
    input  logic             go,
    output logic             stall,
    output logic             halted,
    output logic [31:0]      disp,
    output logic             disp_valid,
    output logic [CNT_W-1:0] sys_cnt
);
    state_t state, state_nxt;
    logic accept, is_print, is_pause, is_exit;
    assign accept   = state == IDLE && syscall;
    assign is_print = v0 == V0_PRINT;
    assign is_pause = v0 == V0_PAUSE;
    assign is_exit  = v0 == V0_EXIT;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state == IDLE   ? (accept && is_pause ? PAUSE : accept && is_exit ? HALT : IDLE) :
                    state == PAUSE  ? (go ? RESUME : PAUSE) :
                    state == RESUME ? IDLE : HALT;
    end
    // reset gating keeps stall low even though IDLE decode would otherwise see syscall
    always_comb begin
        stall = rst_n && (state == PAUSE || state == HALT || (accept && (is_pause || is_exit)));
    end
    assign halted = state == HALT;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            disp       <= '0;
            disp_valid <= 1'b0;
        end else begin
            disp_valid <= accept && is_print;
            if (accept && is_print) disp <= a0;
        end
    sat_counter #(.W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (accept),
        .q    (sys_cnt)
    );
endmodule

// File: tb/tb_syscall_unit.sv
// tb_syscall_unit: directed vector table plus hand sequences for pause, exit, saturation and async reset
module tb_syscall_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        syscall = 1'b0;
    logic [31:0] v0 = '0;
    logic [31:0] a0 = '0;
    logic        go = 1'b0;
    logic        stall, halted, disp_valid;
    logic [31:0] disp;
    logic [3:0]  sys_cnt;
    int n_cmp = 0;
    int n_err = 0;

    syscall_unit #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .syscall   (syscall),
        .v0        (v0),
        .a0        (a0),
        .go        (go),
        .stall     (stall),
        .halted    (halted),
        .disp      (disp),
        .disp_valid(disp_valid),
        .sys_cnt   (sys_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sc;
        logic [31:0] v0;
        logic [31:0] a0;
        logic        go;
        logic        st;
        logic        hl;
        logic [31:0] dp;
        logic        dv;
        logic [3:0]  cnt;
    } vec_t;
    vec_t vt[14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        syscall = 1'b0;
        go = 1'b0;
        v0 = '0;
        a0 = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vt[0]  = '{1'b1, 32'd34, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 4'd1};
        vt[1]  = '{1'b0, 32'd34, 32'h0,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 4'd1};
        vt[2]  = '{1'b1, 32'd7,  32'h1,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 4'd2};
        vt[3]  = '{1'b1, 32'h80000022, 32'h5,  1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 4'd3};
        vt[4]  = '{1'b1, 32'(33'h1_0000_0022), 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b1, 4'd4};
        vt[5]  = '{1'b1, 32'd50, 32'h0,        1'b0, 1'b1, 1'b0, 32'h12345678, 1'b0, 4'd5};
        vt[6]  = '{1'b1, 32'd50, 32'h0,        1'b0, 1'b1, 1'b0, 32'h12345678, 1'b0, 4'd5};
        vt[7]  = '{1'b1, 32'd34, 32'h99,       1'b0, 1'b1, 1'b0, 32'h12345678, 1'b0, 4'd5};
        vt[8]  = '{1'b1, 32'd50, 32'h0,        1'b1, 1'b1, 1'b0, 32'h12345678, 1'b0, 4'd5};
        vt[9]  = '{1'b1, 32'd50, 32'h0,        1'b1, 1'b0, 1'b0, 32'h12345678, 1'b0, 4'd5};
        vt[10] = '{1'b0, 32'd50, 32'h0,        1'b1, 1'b0, 1'b0, 32'h12345678, 1'b0, 4'd5};
        vt[11] = '{1'b1, 32'd10, 32'h0,        1'b0, 1'b1, 1'b1, 32'h12345678, 1'b0, 4'd6};
        vt[12] = '{1'b1, 32'd50, 32'h0,        1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0, 4'd6};
        vt[13] = '{1'b1, 32'd34, 32'h77,       1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0, 4'd6};

        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_disp", disp, 32'd0);
        check("rst_dv", 32'(disp_valid), 32'd0);
        check("rst_cnt", 32'(sys_cnt), 32'd0);
        do_reset();

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            syscall = vt[i].sc;
            v0 = vt[i].v0;
            a0 = vt[i].a0;
            go = vt[i].go;
            #1;
            check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vt[i].st));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_halted", i), 32'(halted), 32'(vt[i].hl));
            check($sformatf("vec%0d_disp", i), disp, vt[i].dp);
            check($sformatf("vec%0d_dv", i), 32'(disp_valid), 32'(vt[i].dv));
            check($sformatf("vec%0d_cnt", i), 32'(sys_cnt), 32'(vt[i].cnt));
        end

        // pause held, resume after five cycles, syscall retires without a second pause
        do_reset();
        @(negedge clk);
        syscall = 1'b1;
        v0 = 32'd50;
        #1;
        check("pause_same_cycle", 32'(stall), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("pause_hold", 32'(stall), 32'd1);
        end
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        #1;
        check("resume_stall", 32'(stall), 32'd0);
        @(negedge clk);
        syscall = 1'b0;
        #1;
        check("after_resume_stall", 32'(stall), 32'd0);
        check("after_resume_cnt", 32'(sys_cnt), 32'd1);
        @(negedge clk);
        #1;
        check("no_second_pause", 32'(stall), 32'd0);

        // exit is terminal until reset
        do_reset();
        @(negedge clk);
        syscall = 1'b1;
        v0 = 32'd10;
        #1;
        check("exit_same_cycle", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        check("exit_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            go = 1'($urandom_range(0, 1));
            syscall = 1'($urandom_range(0, 1));
            v0 = $urandom_range(0, 1) ? 32'd34 : 32'd50;
            #1;
            check("halt_stall", 32'(stall), 32'd1);
            @(posedge clk);
            #1;
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_cnt", 32'(sys_cnt), 32'd1);
            check("halt_dv", 32'(disp_valid), 32'd0);
        end
        @(negedge clk);
        #2;
        syscall = 1'b1;
        v0 = 32'd10;
        rst_n = 1'b0;
        #1;
        check("hrst_stall", 32'(stall), 32'd0);
        check("hrst_halted", 32'(halted), 32'd0);
        check("hrst_disp", disp, 32'd0);
        check("hrst_dv", 32'(disp_valid), 32'd0);
        check("hrst_cnt", 32'(sys_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v0 = 32'd34;
        a0 = 32'hCAFE0001;
        #1;
        check("post_halt_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        check("post_halt_disp", disp, 32'hCAFE0001);
        check("post_halt_dv", 32'(disp_valid), 32'd1);

        // 20 back-to-back print syscalls saturate a 4-bit counter
        do_reset();
        @(negedge clk);
        syscall = 1'b1;
        v0 = 32'd34;
        for (int i = 1; i <= 20; i++) begin
            a0 = 32'(i);
            @(posedge clk);
            #1;
            check($sformatf("sat_cnt%0d", i), 32'(sys_cnt), (i < 15) ? 32'(i) : 32'd15);
        end
        check("sat_disp", disp, 32'd20);

        // async reset mid-PAUSE takes effect before the next edge, no resume cycle
        do_reset();
        @(negedge clk);
        syscall = 1'b1;
        v0 = 32'd50;
        @(negedge clk);
        syscall = 1'b0;
        go = 1'b1;
        #1;
        check("pre_arst_stall", 32'(stall), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_stall", 32'(stall), 32'd0);
        check("arst_cnt", 32'(sys_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        go = 1'b0;
        syscall = 1'b1;
        v0 = 32'd50;
        #1;
        check("arst_idle_accept", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        check("arst_cnt_after", 32'(sys_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/syscall_unit.md
SYSCALL_UNIT -- requirements
Module: syscall_unit

Interface
REQ-001 Parameters SHALL be (name, default, meaning): V0_PRINT, 34, print a0 to display; V0_EXIT, 10, halt CPU; V0_PAUSE, 50, stall CPU until go; CNT_W, 16, syscall counter width.
REQ-002 Port clk SHALL be input, 1 bit, the single clock; all state updates on posedge clk.
REQ-003 Port rst_n SHALL be input, 1 bit, reset; the only reset, asynchronous and active-low.
REQ-004 Port syscall SHALL be input, 1 bit, asserted while the current instruction is SYSCALL.
REQ-005 Port v0 SHALL be input, 32 bits, register $2 contents (syscall code).
REQ-006 Port a0 SHALL be input, 32 bits, register $4 contents (syscall argument).
REQ-007 Port go SHALL be input, 1 bit, resume request; level sampled on posedge clk.
REQ-008 Port stall SHALL be output, 1 bit, combinational; when high the CPU holds PC and suppresses register writes.
REQ-009 Port halted SHALL be output, 1 bit, registered; high while in HALT.
REQ-010 Port disp SHALL be output, 32 bits, registered; last printed value.
REQ-011 Port disp_valid SHALL be output, 1 bit, registered; one-cycle pulse after disp updates.
REQ-012 Port sys_cnt SHALL be output, CNT_W bits, registered; count of accepted syscalls.

Function
REQ-013 FSM states SHALL be IDLE, PAUSE, RESUME and HALT.
REQ-014 An accepted syscall SHALL be syscall=1 sampled in IDLE; syscall in PAUSE, RESUME or HALT SHALL be ignored.
REQ-015 Accepted with v0==V0_PRINT: disp<=a0; disp_valid=1 the following cycle only; state stays IDLE; stall stays 0.
REQ-016 Accepted with v0==V0_PAUSE: stall=1 combinationally in that same cycle; next state PAUSE.
REQ-017 Accepted with v0==V0_EXIT: stall=1 combinationally in that same cycle; next state HALT.
REQ-018 Accepted with any other v0: no effect except the counter; stall=0.
REQ-019 stall SHALL equal (state==PAUSE) or (state==HALT) or (state==IDLE and syscall and v0 in {V0_PAUSE, V0_EXIT}).
REQ-020 PAUSE: stall=1; go=1 moves to RESUME; go=0 stays in PAUSE.
REQ-021 RESUME: exactly one cycle with stall=0 and syscall ignored, so the paused SYSCALL retires without re-triggering; then IDLE.
REQ-022 HALT SHALL be terminal; go and syscall are ignored; only rst_n exits.
REQ-023 go in IDLE or RESUME SHALL be ignored.
REQ-024 sys_cnt SHALL increment by 1 on every accepted syscall, saturating at all-ones with no wrap-around.
REQ-025 v0 comparison SHALL use the full 32 bits; v0 with upper bits set never matches a code.
REQ-026 Every output SHALL depend on a0 and v0 only through the rules above; there is no latency beyond one register stage.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, disp=0, disp_valid=0, sys_cnt=0 and halted=0.
REQ-028 While rst_n is low, stall SHALL be 0 regardless of syscall.
REQ-029 Reset asserted mid-PAUSE or mid-HALT SHALL abort to IDLE with no resume cycle.
REQ-030 After rst_n deasserts, the first posedge SHALL evaluate normally.

Structure
REQ-031 Package mips_sys_pkg SHALL hold the syscall code constants and the FSM state type; the module imports them.
REQ-032 The saturating counter SHALL be a sub-module sat_counter (parameter W; ports clk, rst_n, inc, q).

Verification
REQ-033 Print: v0=34, a0=0xDEADBEEF, syscall for 1 cycle -> next cycle disp=0xDEADBEEF, disp_valid=1 for 1 cycle, stall always 0, sys_cnt=1.
REQ-034 Pause: v0=50, syscall held -> stall=1 same cycle; go=1 after 5 cycles -> RESUME one cycle with stall=0, back to IDLE, sys_cnt=1, no second pause.
REQ-035 Exit: v0=10, syscall -> stall=1 and halted=1 persist for 100 cycles despite go and syscall pulses; rst_n low -> all outputs 0.
REQ-036 Unknown and width checks: v0=0x1_0000_0022 truncated to 32 bits as 0x00000022 -> print; v0=0x80000022 -> no print, sys_cnt increments.
REQ-037 Saturation: CNT_W=4, 20 accepted print syscalls -> sys_cnt=0xF, no wrap to 0.
REQ-038 Async reset in PAUSE, between clock edges -> state IDLE and stall=0 immediately, before the next posedge.
